fx3_tx_sample_buffer: RTL

- Buffers 32-bit hydrophone sample words ahead of the FX3 slave-FIFO write engine.
- Grants the engine either full bursts or, after an idle timeout, one short packet that must be closed with PKTEND.
- Sits directly upstream of the slave-FIFO writer in the clk_100 domain.
- The source cannot stall: words arriving while the buffer is full are dropped and counted.

---
 rtl/fx3_tx_sample_buffer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fx3_tx_sample_buffer.sv
// Sample buffer ahead of the FX3 slave-FIFO writer: grants full bursts, or a short packet after an idle timeout.
// m_data is registered show-ahead (new words visible next cycle); the source cannot stall, so words pushed while full are dropped and counted.
module fx3_tx_sample_buffer #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 10,
  parameter int BURST_WORDS   = 256,
  parameter int FLUSH_TIMEOUT = 1023
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_full,
  output logic [ADDR_W:0]   fill_level,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_rd,
  output logic              m_burst_avail,
  output logic              m_short_avail,
  output logic [ADDR_W:0]   m_short_len,
  input  logic              m_pktend_ack,
  output logic              rd_err,
  output logic [15:0]       overflow_cnt
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam int              TMR_W   = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] BURST_L = (ADDR_W + 1)'(BURST_WORDS);
  localparam logic [TMR_W-1:0] TMO_L  = TMR_W'(FLUSH_TIMEOUT);

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_BURST,
    RD_SHORT,
    RD_WAIT_PKTEND
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_words_left;
  logic [ADDR_W:0]     w_words_left_nxt;
  logic [ADDR_W:0]     r_short_len;
  logic [ADDR_W:0]     w_short_len_nxt;
  logic                w_burst_avail;
  logic                w_short_avail;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W-1:0]   w_rd_ptr_nxt;
  logic [ADDR_W:0]     r_fill;
  logic [ADDR_W:0]     w_fill_nxt;
  logic                r_s_full;
  logic [DATA_W-1:0]   r_m_data;
  logic [TMR_W-1:0]    r_idle_timer;
  logic                r_rd_err;
  logic [15:0]         r_ovf_cnt;

  logic                w_push;
  logic                w_pop;
  logic                w_in_grant;

  assign w_push       = s_valid & ~r_s_full;
  assign w_in_grant   = (r_state == RD_BURST) || (r_state == RD_SHORT);
  assign w_pop        = m_rd & w_in_grant & (r_words_left != '0) & (r_fill != '0);
  assign w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(w_pop);

  always_comb begin
    w_fill_nxt = r_fill;
    if (w_push && !w_pop) begin
      w_fill_nxt = r_fill + 1'b1;
    end else if (!w_push && w_pop) begin
      w_fill_nxt = r_fill - 1'b1;
    end
  end

  always_ff @(posedge clk_100) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_s_full     <= 1'b0;
      r_m_data     <= '0;
      r_idle_timer <= '0;
      r_rd_err     <= 1'b0;
      r_ovf_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_fill   <= w_fill_nxt;
      r_s_full <= (w_fill_nxt == DEPTH_L);
      // Bypass covers a push landing on the slot that becomes the head this cycle.
      if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
        r_m_data <= s_data;
      end else begin
        r_m_data <= r_mem[w_rd_ptr_nxt];
      end
      if (w_push || (r_fill == '0)) begin
        r_idle_timer <= '0;
      end else if ((r_state == RD_WAIT_PKTEND) && m_pktend_ack) begin
        r_idle_timer <= '0;
      end else if ((r_state == RD_IDLE) && (r_idle_timer != TMO_L)) begin
        r_idle_timer <= r_idle_timer + 1'b1;
      end
      if (m_rd && !w_pop) begin
        r_rd_err <= 1'b1;
      end
      if (s_valid && r_s_full && (r_ovf_cnt != 16'hFFFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      r_state      <= RD_IDLE;
      r_words_left <= '0;
      r_short_len  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_words_left <= w_words_left_nxt;
      r_short_len  <= w_short_len_nxt;
    end
  end

  // Grant length is frozen at entry; later pushes wait for the next grant.
  always_comb begin
    w_state_nxt      = r_state;
    w_words_left_nxt = r_words_left - (ADDR_W + 1)'(w_pop);
    w_short_len_nxt  = r_short_len;
    case (r_state)
      RD_IDLE: begin
        if (r_fill >= BURST_L) begin
          w_state_nxt      = RD_BURST;
          w_words_left_nxt = BURST_L;
        end else if ((r_fill != '0) && (r_idle_timer == TMO_L)) begin
          w_state_nxt      = RD_SHORT;
          w_words_left_nxt = r_fill;
          w_short_len_nxt  = r_fill;
        end
      end
      RD_BURST: begin
        if (w_pop && (r_words_left == (ADDR_W + 1)'(1))) begin
          w_state_nxt = RD_IDLE;
        end
      end
      RD_SHORT: begin
        if (w_pop && (r_words_left == (ADDR_W + 1)'(1))) begin
          w_state_nxt = RD_WAIT_PKTEND;
        end
      end
      RD_WAIT_PKTEND: begin
        if (m_pktend_ack) begin
          w_state_nxt = RD_IDLE;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    w_burst_avail = 1'b0;
    w_short_avail = 1'b0;
    case (r_state)
      RD_BURST: w_burst_avail = 1'b1;
      RD_SHORT: w_short_avail = 1'b1;
      default: begin
        w_burst_avail = 1'b0;
        w_short_avail = 1'b0;
      end
    endcase
  end

  assign s_full        = r_s_full;
  assign fill_level    = r_fill;
  assign m_data        = r_m_data;
  assign m_burst_avail = w_burst_avail;
  assign m_short_avail = w_short_avail;
  assign m_short_len   = r_short_len;
  assign rd_err        = r_rd_err;
  assign overflow_cnt  = r_ovf_cnt;

endmodule
